// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised architectural register file: one write port, RD_PORTS
//   registered read ports with write-first bypass, and a clear sequencer that
//   zeroes the array one entry per enabled cycle.
//
//   Optional feature macro: REGFILE_ZERO_REG_EN
//     defined   -> entry 0 reads as zero; writes to it are silently discarded
//     undefined -> entry 0 is an ordinary register
//
// Parameters
//   DATA_W    data width in bits
//   DEPTH     number of entries (>= 2, any value)
//   RD_PORTS  number of read ports (1..4)
//   ADDR_W    derived address width, not overridable
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active low
//   en        global enable; low freezes array, outputs and sweep
//   wr_en     write request
//   wr_addr   write address
//   wr_data   write data
//   rd_en     read request for all ports
//   rd_addr   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   packed registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_valid  rd_data was updated by a read at the previous edge
//   clr_req   start a clear sweep
//   busy      clear sweep in progress
//   wr_drop   one-cycle pulse: a write request was discarded
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned RD_PORTS = 2,
    localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic                         rd_valid,
    input  logic                         clr_req,
    output logic                         busy,
    output logic                         wr_drop
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                     state;
    logic [ADDR_W-1:0]          clr_ptr;
    logic [DATA_W-1:0]          mem [DEPTH];

    logic                       wr_in_range;
    logic                       wr_zero;
    logic                       wr_ok;
    logic [RD_PORTS*DATA_W-1:0] rd_next;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    // Address that is hardwired to zero when the zero-register option is built in.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
        return a == '0;
`else
        return (a == '0) & 1'b0;
`endif
    endfunction

    // Write qualification, meaningful only on a normal-access cycle.
    assign wr_in_range = in_range(wr_addr);
    assign wr_zero     = is_zero_reg(wr_addr);
    assign wr_ok       = wr_en & wr_in_range & ~wr_zero;

    // Per-port read word with write-first bypass; out-of-range and zero-reg read as 0.
    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            word = '0;
            if (in_range(addr) && !is_zero_reg(addr)) begin
                if (wr_ok && (wr_addr == addr)) begin
                    word = wr_data;
                end else begin
                    word = mem[addr];
                end
            end
        end

        assign rd_next[k*DATA_W +: DATA_W] = word;
    end

    // Sequencer, array and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            clr_ptr  <= '0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            wr_drop  <= 1'b0;
            rd_data  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            rd_valid <= 1'b0;
            wr_drop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        // Sweep start takes the cycle; a coincident write is lost.
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_ptr <= '0;
                        wr_drop <= wr_en;
                    end else begin
                        if (wr_ok) begin
                            mem[wr_addr] <= wr_data;
                        end
                        if (wr_en && !wr_in_range) begin
                            wr_drop <= 1'b1;
                        end
                        if (rd_en) begin
                            rd_valid <= 1'b1;
                            rd_data  <= rd_next;
                        end
                    end
                end
                CLEAR: begin
                    mem[clr_ptr] <= '0;
                    wr_drop      <= wr_en;
                    if (clr_ptr == LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end else begin
            rd_valid <= 1'b0;
            wr_drop  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Scoreboard bench for regfile_mp (DEPTH=20, two 32-bit read ports).
//   Stimulus pushes per-cycle expected control values and expected read data;
//   a monitor pops and compares on the falling edge. Honors REGFILE_ZERO_REG_EN.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 20;
    localparam int unsigned NP  = 2;
    localparam int unsigned AW  = 5;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              en;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              rd_en;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic              rd_valid;
    logic              clr_req;
    logic              busy;
    logic              wr_drop;

    regfile_mp #(.DATA_W(DW), .DEPTH(DEP), .RD_PORTS(NP)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_drop  (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic d;
        logic b;
    } ctrl_t;

    ctrl_t        ctrl_q [$];
    logic [63:0]  data_q [$];
    int           applied = 0;
    int           errors  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the expected outputs after the following edge.
    task automatic cyc(input logic e, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic cl, input logic xv, input logic xd, input logic xb,
                       input logic [DW-1:0] x0, input logic [DW-1:0] x1);
        @(negedge clk);
        #1;
        en      = e;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = {a1, a0};
        clr_req = cl;
        ctrl_q.push_back('{v: xv, d: xd, b: xb});
        if (xv) data_q.push_back({x1, x0});
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] x0, input logic [DW-1:0] x1);
        cyc(1, 0, '0, '0, 1, a0, a1, 0, 1, 0, 0, x0, x1);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic xd);
        cyc(1, 1, a, d, 0, '0, '0, 0, 0, xd, 0, '0, '0);
    endtask

    task automatic idle(input logic xb);
        cyc(1, 0, '0, '0, 0, '0, '0, 0, 0, 0, xb, '0, '0);
    endtask

    // Value held by entry i after the fill loop.
    function automatic logic [DW-1:0] fill_val(input int i);
        return (ZR && i == 0) ? '0 : DW'(i + 1);
    endfunction

    // Monitor: control every cycle, data whenever a read was expected.
    initial begin
        ctrl_t       c;
        logic [63:0] d;
        forever begin
            @(negedge clk);
            if (ctrl_q.size() > 0) begin
                c = ctrl_q.pop_front();
                chk("rd_valid", 64'(rd_valid), 64'(c.v));
                chk("wr_drop",  64'(wr_drop),  64'(c.d));
                chk("busy",     64'(busy),     64'(c.b));
                if (c.v) begin
                    d = data_q.pop_front();
                    if (rd_valid) chk("rd_data", rd_data, d);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] zexp;
        zexp    = ZR ? 32'h0 : 32'h0000_1234;
        rst     = 1'b1;
        en      = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        clr_req = 1'b0;
        #2 rst  = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("reset rd_valid", 64'(rd_valid), 64'd0);
        chk("reset busy",     64'(busy),     64'd0);
        chk("reset wr_drop",  64'(wr_drop),  64'd0);
        chk("reset rd_data",  rd_data,       64'd0);
        rst = 1'b1;

        // Every entry reads zero after reset
        for (int i = 0; i < DEP; i++) rd(AW'(i), AW'(DEP - 1 - i), '0, '0);

        // Write with same-cycle read of the same address on both ports
        cyc(1, 1, 5, 32'hDEAD_BEEF, 1, 5, 5, 0, 1, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        rd(5, 0, 32'hDEAD_BEEF, 32'h0);

        // Fill with i+1 and read back in a rotated order
        for (int i = 0; i < DEP; i++) wr(AW'(i), DW'(i + 1), 1'b0);
        for (int i = 0; i < DEP; i++) rd(AW'(i), AW'((i + 7) % DEP), fill_val(i), fill_val((i + 7) % DEP));

        // Out-of-range write drops, out-of-range read returns zero
        wr(25, 32'h77, 1'b1);
        rd(25, 3, 32'h0, 32'd4);
        wr(19, 32'h99, 1'b0);
        rd(19, 31, 32'h99, 32'h0);

        // Clear sweep: DEPTH enabled busy cycles, plus three paused cycles
        cyc(1, 0, '0, '0, 0, '0, '0, 1, 0, 0, 1, '0, '0);
        for (int j = 1; j < DEP; j++) begin
            if (j == 8) begin
                repeat (3) cyc(0, 1, 2, 32'hF00D, 1, 2, 2, 1, 0, 0, 1, '0, '0);
            end
            if (j == 10) cyc(1, 1, 2, 32'hBAD, 1, 2, 2, 0, 0, 1, 1, '0, '0);
            else         idle(1'b1);
        end
        // Last sweep cycle: read still ignored, busy drops afterwards
        cyc(1, 0, '0, '0, 1, 3, 4, 0, 0, 0, 0, '0, '0);
        rd(3, 4, '0, '0);
        for (int i = 0; i < DEP; i++) rd(AW'(i), AW'((i + 1) % DEP), '0, '0);

        // Write and read of entry 0 in the same cycle
        cyc(1, 1, 0, 32'h1234, 1, 0, 0, 0, 1, 0, 0, zexp, zexp);
        rd(0, 0, zexp, zexp);

        // Reset in the middle of a sweep at clr_ptr = 10
        wr(15, 32'h55, 1'b0);
        rd(15, 15, 32'h55, 32'h55);
        cyc(1, 0, '0, '0, 0, '0, '0, 1, 0, 0, 1, '0, '0);
        repeat (10) idle(1'b1);
        @(negedge clk);
        #1;
        en      = 1'b0;
        clr_req = 1'b0;
        rst     = 1'b0;
        #1;
        chk("midsweep busy",     64'(busy),     64'd0);
        chk("midsweep rd_valid", 64'(rd_valid), 64'd0);
        chk("midsweep wr_drop",  64'(wr_drop),  64'd0);
        chk("midsweep rd_data",  rd_data,       64'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        rd(15, 0, '0, '0);
        rd(12, 19, '0, '0);

        repeat (2) @(negedge clk);
        #1;
        chk("ctrl queue drained", 64'(ctrl_q.size()), 64'd0);
        chk("data queue drained", 64'(data_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
